// File: rtl/pkt_router.sv
// pkt_router: parses DD/chan/sub/len/payload/CRC frames from the UART byte
// stream, buffers the payload and forwards it to the addressed channel.
// Optional macro BOS_CRC_CHECK_EN enables the payload-sum CRC comparison;
// without it the CRC byte is consumed unchecked.
module pkt_router #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned BUF_DEPTH   = 64,
    parameter logic [7:0]  PREFIX      = 8'hDD,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       master_data,
    output logic [N_SRC-1:0] valid_bus,
    input  logic [N_SRC-1:0] ready_bus,
    output logic [7:0]       sub_addr,
    output logic             pkt_ok,
    output logic             pkt_err,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int unsigned CW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned PW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHAN, S_SUB, S_LEN, S_DATA, S_CRC, S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        chan_q, chan_d;
    logic [7:0]        sub_q, sub_d;
    logic [7:0]        len_q, len_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        md_q, md_d;
    logic [N_SRC-1:0]  vb_q, vb_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic [1:0]        ec_q, ec_d;
    logic              busy_q, busy_d;
    logic              mem_we_c;
    logic              chan_ok_c;
    logic              crc_match_c;
    logic [CW-1:0]     chan_idx_c;
    logic [7:0]        mem_q [BUF_DEPTH];
`ifdef BOS_CRC_CHECK_EN
    logic [7:0]        crc_q, crc_d;
`endif

    assign master_data = md_q;
    assign valid_bus   = vb_q;
    assign sub_addr    = sub_q;
    assign pkt_ok      = ok_q;
    assign pkt_err     = err_q;
    assign err_code    = ec_q;
    assign busy        = busy_q;

    assign chan_ok_c  = (chan_q < 8'(N_SRC));
    assign chan_idx_c = chan_q[CW-1:0];
`ifdef BOS_CRC_CHECK_EN
    assign crc_match_c = (rx_data == crc_q);
`else
    assign crc_match_c = 1'b1;
`endif

    // Payload buffer write port; contents need no reset since pointers gate use.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            chan_q   <= '0;
            sub_q    <= '0;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tmo_q    <= '0;
            md_q     <= '0;
            vb_q     <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            ec_q     <= '0;
            busy_q   <= 1'b0;
`ifdef BOS_CRC_CHECK_EN
            crc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            sub_q    <= sub_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tmo_q    <= tmo_d;
            md_q     <= md_d;
            vb_q     <= vb_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            ec_q     <= ec_d;
            busy_q   <= busy_d;
`ifdef BOS_CRC_CHECK_EN
            crc_q    <= crc_d;
`endif
        end
    end

    // Frame parser, drain sequencer and inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        sub_d    = sub_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tmo_d    = tmo_q;
        md_d     = md_q;
        vb_d     = vb_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        ec_d     = ec_q;
        mem_we_c = 1'b0;
`ifdef BOS_CRC_CHECK_EN
        crc_d    = crc_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_data == PREFIX)) begin
                    state_d  = S_CHAN;
                    tmo_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
`ifdef BOS_CRC_CHECK_EN
                    crc_d    = '0;
`endif
                end
            end
            S_DRAIN: begin
                // rx bytes arriving here are dropped; first byte needs one read cycle
                if (vb_q == '0) begin
                    md_d = mem_q[rd_ptr_q[AW-1:0]];
                    vb_d = N_SRC'(1) << chan_idx_c;
                end else if (ready_bus[chan_idx_c]) begin
                    if (rd_ptr_q == PW'(len_q - 8'd1)) begin
                        vb_d    = '0;
                        ok_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        md_d     = mem_q[AW'(rd_ptr_q + PW'(1))];
                    end
                end
            end
            default: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    case (state_q)
                        S_CHAN: begin
                            chan_d  = rx_data;
                            state_d = S_SUB;
                        end
                        S_SUB: begin
                            sub_d   = rx_data;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            len_d = rx_data;
                            if ((rx_data == 8'd0) || (rx_data > 8'(BUF_DEPTH))) begin
                                err_d   = 1'b1;
                                ec_d    = 2'd2;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                        S_DATA: begin
                            mem_we_c = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
`ifdef BOS_CRC_CHECK_EN
                            crc_d    = crc_q + rx_data;
`endif
                            if (wr_ptr_q == PW'(len_q - 8'd1)) state_d = S_CRC;
                        end
                        S_CRC: begin
                            if (chan_ok_c && crc_match_c) begin
                                state_d  = S_DRAIN;
                                rd_ptr_d = '0;
                            end else begin
                                err_d   = 1'b1;
                                ec_d    = chan_ok_c ? 2'd0 : 2'd1;
                                state_d = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    ec_d    = 2'd3;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_pkt_router.sv
// Directed bench for pkt_router: frames, back-pressure, errors, timeout, reset.
`timescale 1ns/1ps
module tb_pkt_router;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] master_data;
    logic [3:0] valid_bus;
    logic [3:0] ready_bus;
    logic [7:0] sub_addr;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    pkt_router dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .master_data(master_data), .valid_bus(valid_bus), .ready_bus(ready_bus),
        .sub_addr(sub_addr), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // monitor state
    int         cyc = 0;
    int         n_ok = 0, n_err = 0, n_both = 0, n_badvb = 0, n_stallchg = 0;
    logic [1:0] last_ec = '0;
    logic [7:0] xq [$];
    int         xc [$];
    logic [7:0] xs [$];
    logic [3:0] exp_vb = 4'b0010;
    logic [3:0] ready_cfg = 4'hF;
    logic       bp_mode = 1'b0;
    logic [7:0] txq [$];

    int b_ok, b_err, b_x, b_badvb, b_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // ready driver: plain config or bit 1 toggling each clock
    initial begin
        logic tog;
        tog = 1'b0;
        ready_bus = 4'hF;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                tog = ~tog;
                ready_bus = {ready_cfg[3:2], tog, ready_cfg[0]};
            end else begin
                ready_bus = ready_cfg;
            end
        end
    end

    // output monitor sampled on the falling edge
    initial begin
        logic       pv, pr;
        logic [7:0] pmd;
        pv = 1'b0; pr = 1'b0; pmd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (pkt_ok) n_ok++;
                if (pkt_err) begin n_err++; last_ec = err_code; end
                if (pkt_ok && pkt_err) n_both++;
                if (valid_bus != 4'b0000) begin
                    if (valid_bus != exp_vb) n_badvb++;
                    if ((valid_bus & ready_bus) != 4'b0000) begin
                        xq.push_back(master_data);
                        xc.push_back(cyc);
                        xs.push_back(sub_addr);
                    end
                end
                if (pv && !pr && (master_data != pmd)) n_stallchg++;
                pv  = (valid_bus != 4'b0000);
                pr  = ((valid_bus & ready_bus) != 4'b0000);
                pmd = master_data;
            end else begin
                pv = 1'b0; pr = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_ok = n_ok; b_err = n_err; b_x = xq.size(); b_badvb = n_badvb; b_stall = n_stallchg;
    endtask

    task automatic send_txq();
        foreach (txq[i]) begin
            rx_data  = txq[i];
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && (k < budget)) begin
            step();
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
        repeat (3) step();
    endtask

    // expected payload of n bytes starting at first, with given sub address
    task automatic chk_payload(input string tag, input int n, input logic [7:0] first,
                               input logic [7:0] step_v, input logic [7:0] sub);
        logic [7:0] e;
        chk({tag, "_nxfer"}, 32'(xq.size() - b_x), 32'(n));
        e = first;
        for (int i = 0; i < n; i++) begin
            if (xq.size() > b_x + i) begin
                chk($sformatf("%s_d%0d", tag, i), 32'(xq[b_x+i]), 32'(e));
                if (i == 0) chk({tag, "_sub"}, 32'(xs[b_x]), 32'(sub));
            end
            e = e + step_v;
        end
        chk({tag, "_badvb"}, 32'(n_badvb - b_badvb), 0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vb", 32'(valid_bus), 0);
        chk("rst_md", 32'(master_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ec", 32'(err_code), 0);
        chk("rst_pulses", 32'({pkt_ok, pkt_err}), 0);
        chk("rst_sub", 32'(sub_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // good frame, always ready
        exp_vb = 4'b0010;
        snap();
        txq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        send_txq();
        wait_idle("good", 100);
        chk("good_ok", 32'(n_ok - b_ok), 1);
        chk("good_err", 32'(n_err - b_err), 0);
        chk_payload("good", 6, 8'h01, 8'h01, 8'h00);
        if (xq.size() >= b_x + 6) chk("good_span", 32'(xc[b_x+5] - xc[b_x]), 5);

        // back-pressure on channel 1
        bp_mode = 1'b1;
        step();
        snap();
        send_txq();
        wait_idle("bp", 200);
        bp_mode = 1'b0;
        chk("bp_ok", 32'(n_ok - b_ok), 1);
        chk("bp_err", 32'(n_err - b_err), 0);
        chk_payload("bp", 6, 8'h01, 8'h01, 8'h00);
        chk("bp_stable", 32'(n_stallchg - b_stall), 0);
        if (xq.size() >= b_x + 6) chk("bp_span", 32'((xc[b_x+5] - xc[b_x]) > 5), 1);
        step();

        // bad CRC to channel 2
        exp_vb = 4'b0100;
        snap();
        txq = '{8'hDD, 8'h02, 8'h05, 8'h03, 8'h10, 8'h20, 8'h30, 8'h61};
        send_txq();
        wait_idle("bcrc", 100);
`ifdef BOS_CRC_CHECK_EN
        chk("bcrc_err", 32'(n_err - b_err), 1);
        chk("bcrc_ec", 32'(last_ec), 0);
        chk("bcrc_ok", 32'(n_ok - b_ok), 0);
        chk("bcrc_nxfer", 32'(xq.size() - b_x), 0);
`else
        chk("bcrc_err", 32'(n_err - b_err), 0);
        chk("bcrc_ok", 32'(n_ok - b_ok), 1);
        chk_payload("bcrc", 3, 8'h10, 8'h10, 8'h05);
`endif

        // following good frame on channel 2
        snap();
        txq = '{8'hDD, 8'h02, 8'h05, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        send_txq();
        wait_idle("g2", 100);
        chk("g2_ok", 32'(n_ok - b_ok), 1);
        chk("g2_err", 32'(n_err - b_err), 0);
        chk_payload("g2", 3, 8'h10, 8'h10, 8'h05);

        // zero length
        snap();
        txq = '{8'hDD, 8'h00, 8'h00, 8'h00};
        send_txq();
        wait_idle("len0", 20);
        chk("len0_err", 32'(n_err - b_err), 1);
        chk("len0_ec", 32'(last_ec), 2);

        // length 65 followed by garbage
        snap();
        txq = '{8'hDD, 8'h00, 8'h00, 8'h41, 8'h11, 8'h22, 8'h33};
        send_txq();
        wait_idle("len65", 20);
        chk("len65_err", 32'(n_err - b_err), 1);
        chk("len65_ec", 32'(last_ec), 2);

        // bad channel, frame parsed to its end
        snap();
        txq = '{8'hDD, 8'h07, 8'h00, 8'h01, 8'hAA, 8'hAA};
        send_txq();
        wait_idle("bchan", 20);
        chk("bchan_err", 32'(n_err - b_err), 1);
        chk("bchan_ec", 32'(last_ec), 1);
        chk("bchan_nxfer", 32'(xq.size() - b_x), 0);
        chk("bchan_ok", 32'(n_ok - b_ok), 0);

        // inter-byte timeout
        snap();
        txq = '{8'hDD, 8'h01, 8'h00};
        send_txq();
        repeat (49990) step();
        chk("tmo_busy_early", 32'(busy), 1);
        chk("tmo_noerr_early", 32'(n_err - b_err), 0);
        wait_idle("tmo", 100);
        chk("tmo_err", 32'(n_err - b_err), 1);
        chk("tmo_ec", 32'(last_ec), 3);

        // reset while stalled in drain
        exp_vb = 4'b0010;
        ready_cfg = 4'h0;
        step();
        snap();
        txq = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        send_txq();
        repeat (5) step();
        chk("rstd_vb", 32'(valid_bus), 32'h2);
        chk("rstd_md", 32'(master_data), 32'h01);
        chk("rstd_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstd_vb_post", 32'(valid_bus), 0);
        chk("rstd_busy_post", 32'(busy), 0);
        ready_cfg = 4'hF;
        repeat (5) step();
        chk("rstd_ok", 32'(n_ok - b_ok), 0);
        chk("rstd_err", 32'(n_err - b_err), 0);

        // garbage then good frame
        snap();
        txq = '{8'h00, 8'hFF, 8'h5A,
                8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        send_txq();
        wait_idle("garb", 100);
        chk("garb_ok", 32'(n_ok - b_ok), 1);
        chk("garb_err", 32'(n_err - b_err), 0);
        chk_payload("garb", 6, 8'h01, 8'h01, 8'h00);

        chk("never_both", 32'(n_both), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pkt_router.md
Name: pkt_router

Overview:
- Host-link packet controller between the UART receiver byte stream (rx_data/rx_valid) and the N_SRC on-board peripheral controllers (DAC, power DACs, power ADC, ...).
- Parses frames of the form 0xDD prefix, channel address, sub-address, length, payload, CRC.
- Buffers the payload, checks the CRC, then forwards the payload byte-by-byte to the selected channel over a shared master_data bus with a per-channel valid/ready handshake.

Parameters:
- N_SRC, 4, number of destination channels; width of valid_bus/ready_bus.
- BUF_DEPTH, 64, payload buffer depth in bytes; maximum accepted length field.
- PREFIX, 8'hDD, frame start byte.
- TIMEOUT_CYC, 50000, maximum clocks allowed between two received bytes of one frame (about 1 ms at 48 MHz).

Ports:
- clk  in  1  system clock (48 MHz domain).
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- master_data  out  8  payload byte broadcast to all channels.
- valid_bus  out  N_SRC  one-hot; bit k means master_data is valid for channel k.
- ready_bus  in  N_SRC  channel k can accept a byte.
- sub_addr  out  8  sub-address of the frame being forwarded; stable during DRAIN.
- pkt_ok  out  1  one-cycle pulse when the last payload byte is accepted.
- pkt_err  out  1  one-cycle pulse when a frame is rejected.
- err_code  out  2  cause of the last error: 0 CRC, 1 bad channel, 2 bad length, 3 timeout. Held until the next error.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; master_data=0, valid_bus=0, sub_addr=0, pkt_ok=0, pkt_err=0, err_code=0, busy=0; buffer pointers, CRC accumulator and timeout counter cleared. Reset mid-frame or mid-drain aborts immediately, with no pkt_err.
- FSM states: IDLE, CHAN, SUB, LEN, DATA, CRC, DRAIN. Each state except IDLE and DRAIN advances on rx_valid.
- IDLE: on rx_valid with rx_data==PREFIX go to CHAN. Any other byte is silently discarded.
- CHAN: latch the channel index. If the index is ≥ N_SRC, the frame is still parsed to its end and then rejected with err_code=1.
- SUB: latch sub_addr.
- LEN: latch len. If len==0 or len>BUF_DEPTH, raise pkt_err with err_code=2 one cycle after the LEN byte and return to IDLE; the rest of the frame is then hunted as garbage.
- DATA: write each byte to the buffer at wr_ptr, add it to the CRC accumulator (8-bit sum, modulo 256, payload bytes only), increment wr_ptr. After len bytes go to CRC.
- CRC: compare the received byte with the accumulator.
  - Match and channel valid: go to DRAIN.
  - Otherwise: pkt_err the next cycle, with err_code=1 taking priority over err_code=0.
- DRAIN:
  - master_data=buf[rd_ptr]; valid_bus bit [chan] is high and all other bits low.
  - A byte transfers on a cycle where valid and ready_bus[chan] are both high; rd_ptr then increments and the next byte is presented the following cycle. A continuously ready channel therefore accepts one byte per clock.
  - After the len-th transfer: valid_bus=0, pkt_ok pulses for one cycle, state returns to IDLE.
  - Buffer read latency is one clock; the first valid is asserted ≥1 cycle after the CRC byte.
  - rx_valid during DRAIN is dropped.
- Timeout: the counter resets on every rx_valid and runs in CHAN..CRC. On reaching TIMEOUT_CYC: pkt_err, err_code=3, return to IDLE. The counter does not run in DRAIN.
- pkt_ok and pkt_err are never high in the same cycle.
- master_data holds its last value when valid_bus=0.

Optional Feature:
- Macro: BOS_CRC_CHECK_EN.
- Defined: the CRC comparison operates as described above.
- Undefined: the CRC byte is consumed but not compared; a valid channel always proceeds to DRAIN and err_code=0 is never produced. The accumulator logic is removed.

Test Plan:
- Good frame to a ready channel:
  - Stimulus: DD 01 00 06 01 02 03 04 05 06 15, with ready_bus=all 1.
  - Response: valid_bus=4'b0010 for six consecutive cycles; master_data=01..06; sub_addr=00; one pkt_ok; no pkt_err.
- Back-pressure:
  - Stimulus: the same frame with ready_bus[1] toggling every other cycle.
  - Response: six transfers in order, master_data stable while ready is low, pkt_ok after the sixth transfer.
- Bad CRC:
  - Stimulus: DD 02 05 03 10 20 30 61 (CRC should be 0x60).
  - Response: no valid_bus activity; pkt_err with err_code=0. A following good frame is accepted.
- Bad length and channel:
  - Stimulus: DD 00 00 00, then DD 00 00 41 (len>64), then DD 07 00 01 AA AA.
  - Response: err_code=2, then 2, then 1. The garbage bytes after the second frame are discarded without errors.
- Timeout and reset abort:
  - Timeout stimulus: DD 01 00, then idle for 50000 clocks. Response: pkt_err with err_code=3.
  - Reset stimulus: assert rst for one cycle mid-DRAIN. Response: valid_bus=0 on the next cycle, busy=0, no pkt_ok.
- Garbage then frame:
  - Stimulus: 00 FF 5A, then a good frame.
  - Response: the first three bytes are ignored and the frame is forwarded normally.
